// File: rtl/hwpe_ctrl_tile_sequencer_pkg.sv
// ============================================================================
// Module      : hwpe_ctrl_package
// Description : Shared types for the HWPE tile sequencer: job configuration,
//               output flag bundle and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hwpe_ctrl_package;

    localparam int unsigned HWPE_CTRL_CNT_WIDTH  = 16;
    localparam int unsigned HWPE_CTRL_ADDR_WIDTH = 32;

    // Job configuration captured on start.
    typedef struct packed {
        logic [HWPE_CTRL_CNT_WIDTH-1:0]  n_tiles;
        logic [HWPE_CTRL_ADDR_WIDTH-1:0] base_addr;
        logic [HWPE_CTRL_ADDR_WIDTH-1:0] stride;
    } tile_seq_cfg_t;

    // Status/flag outputs of the sequencer.
    typedef struct packed {
        logic                           tile_valid;
        logic [HWPE_CTRL_CNT_WIDTH-1:0] tile_idx;
        logic                           tile_last;
        logic                           tile_evt;
        logic                           done;
        logic                           busy;
        logic                           err;
    } tile_seq_flags_t;

    typedef enum logic [1:0] {
        TS_IDLE  = 2'd0,
        TS_ISSUE = 2'd1,
        TS_WAIT  = 2'd2,
        TS_DONE  = 2'd3
    } tile_seq_state_t;

endpackage : hwpe_ctrl_package

`default_nettype wire

// File: rtl/hwpe_ctrl_tile_sequencer_addrgen.sv
// ============================================================================
// Module      : hwpe_ctrl_tile_addrgen
// Description : Tile index counter plus address accumulator.
//               clk_i/rst_ni  : clock, async active-low reset
//               clear_i       : synchronous clear (highest priority)
//               load_i        : idx <= 0, addr <= base_i
//               step_i        : idx <= idx+1, addr <= addr+stride_i (wraps)
//               n_tiles_i     : job tile count, used for the last flag
//               idx_o/addr_o  : current tile index / address
//               last_o        : idx_o == n_tiles_i-1
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpe_ctrl_tile_addrgen #(
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic [CNT_WIDTH-1:0]  n_tiles_i,
    output logic [CNT_WIDTH-1:0]  idx_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    logic [CNT_WIDTH-1:0]  idx_q,  idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_comb begin
        idx_d  = idx_q;
        addr_d = addr_q;
        if (clear_i) begin
            idx_d  = '0;
            addr_d = '0;
        end else if (load_i) begin
            idx_d  = '0;
            addr_d = base_i;
        end else if (step_i) begin
            idx_d  = idx_q + CNT_WIDTH'(1);
            addr_d = addr_q + stride_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= '0;
            addr_q <= '0;
        end else begin
            idx_q  <= idx_d;
            addr_q <= addr_d;
        end
    end

    assign idx_o  = idx_q;
    assign addr_o = addr_q;
    // Step is never issued on the last tile, so idx cannot pass n_tiles-1.
    assign last_o = (idx_q == (n_tiles_i - CNT_WIDTH'(1)));

endmodule : hwpe_ctrl_tile_addrgen

`default_nettype wire

// File: rtl/hwpe_ctrl_tile_sequencer.sv
// ============================================================================
// Module      : hwpe_ctrl_tile_sequencer
// Description : Latches a job on start_i and issues its tiles one at a time
//               over a valid/ready handshake, waiting for each tile's
//               completion before issuing the next; pulses done_o at the end.
//               Inputs : clk_i, rst_ni, clear_i, start_i, cfg_*_i,
//                        tile_ready_i, tile_done_i
//               Outputs: tile_valid_o/addr_o/idx_o/last_o (tile request),
//                        tile_evt_o, done_o, busy_o, err_o (status)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpe_ctrl_tile_sequencer
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned CNT_WIDTH  = HWPE_CTRL_CNT_WIDTH,
    parameter int unsigned ADDR_WIDTH = HWPE_CTRL_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  cfg_n_tiles_i,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr_i,
    input  logic [ADDR_WIDTH-1:0] cfg_stride_i,
    output logic                  tile_valid_o,
    input  logic                  tile_ready_i,
    output logic [ADDR_WIDTH-1:0] tile_addr_o,
    output logic [CNT_WIDTH-1:0]  tile_idx_o,
    output logic                  tile_last_o,
    input  logic                  tile_done_i,
    output logic                  tile_evt_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  err_o
);

    tile_seq_state_t state_q;
    tile_seq_cfg_t   cfg_q;
    tile_seq_flags_t flags;
    logic            evt_q;
    logic            err_q;

    logic            ag_load;
    logic            ag_step;
    logic            ag_last;
    logic [CNT_WIDTH-1:0]  ag_idx;
    logic [ADDR_WIDTH-1:0] ag_addr;

    // The counter loads base straight from the input on the start cycle,
    // in parallel with cfg_q capturing it.
    assign ag_load = (state_q == TS_IDLE) && start_i;
    assign ag_step = (state_q == TS_WAIT) && tile_done_i && !ag_last;

    hwpe_ctrl_tile_addrgen #(
        .CNT_WIDTH  (CNT_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addrgen (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .load_i    (ag_load),
        .step_i    (ag_step),
        .base_i    (cfg_base_addr_i),
        .stride_i  (cfg_q.stride),
        .n_tiles_i (cfg_q.n_tiles),
        .idx_o     (ag_idx),
        .addr_o    (ag_addr),
        .last_o    (ag_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TS_IDLE;
            cfg_q   <= '0;
            evt_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (clear_i) begin
            state_q <= TS_IDLE;
            cfg_q   <= '0;
            evt_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            evt_q <= 1'b0;
            // Completion is only legal after acceptance, i.e. in WAIT;
            // a done in the handshake cycle of ISSUE is also an error.
            if (tile_done_i && (state_q != TS_WAIT)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                TS_IDLE: begin
                    if (start_i) begin
                        cfg_q.n_tiles   <= cfg_n_tiles_i;
                        cfg_q.base_addr <= cfg_base_addr_i;
                        cfg_q.stride    <= cfg_stride_i;
                        state_q <= (cfg_n_tiles_i != '0) ? TS_ISSUE : TS_DONE;
                    end
                end
                TS_ISSUE: begin
                    if (tile_ready_i) begin
                        state_q <= TS_WAIT;
                    end
                end
                TS_WAIT: begin
                    if (tile_done_i) begin
                        evt_q   <= 1'b1;
                        state_q <= ag_last ? TS_DONE : TS_ISSUE;
                    end
                end
                TS_DONE: begin
                    state_q <= TS_IDLE;
                end
                default: begin
                    state_q <= TS_IDLE;
                end
            endcase
        end
    end

    // Every flag is either a register or a decode of the registered state.
    assign flags.tile_valid = (state_q == TS_ISSUE);
    assign flags.tile_idx   = ag_idx;
    assign flags.tile_last  = ((state_q == TS_ISSUE) || (state_q == TS_WAIT)) && ag_last;
    assign flags.tile_evt   = evt_q;
    assign flags.done       = (state_q == TS_DONE);
    assign flags.busy       = (state_q != TS_IDLE);
    assign flags.err        = err_q;

    assign tile_valid_o = flags.tile_valid;
    assign tile_addr_o  = ag_addr;
    assign tile_idx_o   = flags.tile_idx;
    assign tile_last_o  = flags.tile_last;
    assign tile_evt_o   = flags.tile_evt;
    assign done_o       = flags.done;
    assign busy_o       = flags.busy;
    assign err_o        = flags.err;

endmodule : hwpe_ctrl_tile_sequencer

`default_nettype wire

// File: tb/tb_hwpe_ctrl_tile_sequencer.sv
// ============================================================================
// Module      : tb_hwpe_ctrl_tile_sequencer
// Description : Directed self-checking bench for the tile sequencer.
//               Inputs are driven and outputs sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hwpe_ctrl_tile_sequencer;

    localparam int unsigned CNT_WIDTH  = 16;
    localparam int unsigned ADDR_WIDTH = 32;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  clear_i;
    logic                  start_i;
    logic [CNT_WIDTH-1:0]  cfg_n_tiles_i;
    logic [ADDR_WIDTH-1:0] cfg_base_addr_i;
    logic [ADDR_WIDTH-1:0] cfg_stride_i;
    logic                  tile_valid_o;
    logic                  tile_ready_i;
    logic [ADDR_WIDTH-1:0] tile_addr_o;
    logic [CNT_WIDTH-1:0]  tile_idx_o;
    logic                  tile_last_o;
    logic                  tile_done_i;
    logic                  tile_evt_o;
    logic                  done_o;
    logic                  busy_o;
    logic                  err_o;

    int n_asserts = 0;
    int n_fails   = 0;

    always #5 clk_i = ~clk_i;

    hwpe_ctrl_tile_sequencer #(
        .CNT_WIDTH  (CNT_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clear_i         (clear_i),
        .start_i         (start_i),
        .cfg_n_tiles_i   (cfg_n_tiles_i),
        .cfg_base_addr_i (cfg_base_addr_i),
        .cfg_stride_i    (cfg_stride_i),
        .tile_valid_o    (tile_valid_o),
        .tile_ready_i    (tile_ready_i),
        .tile_addr_o     (tile_addr_o),
        .tile_idx_o      (tile_idx_o),
        .tile_last_o     (tile_last_o),
        .tile_done_i     (tile_done_i),
        .tile_evt_o      (tile_evt_o),
        .done_o          (done_o),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    task automatic cyc();
        @(negedge clk_i);
    endtask

    // Pulse start for one cycle with the given configuration; returns at the
    // falling edge after the start edge, with cfg inputs scrambled.
    task automatic start_job(input logic [CNT_WIDTH-1:0] n,
                             input logic [ADDR_WIDTH-1:0] base,
                             input logic [ADDR_WIDTH-1:0] stride);
        cfg_n_tiles_i   = n;
        cfg_base_addr_i = base;
        cfg_stride_i    = stride;
        start_i         = 1'b1;
        cyc();
        start_i         = 1'b0;
        cfg_n_tiles_i   = 16'hBEEF;
        cfg_base_addr_i = 32'hDEAD_0000;
        cfg_stride_i    = 32'h0000_0123;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tile_valid_o) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        n_asserts++;
        if ({tile_valid_o, tile_last_o, tile_evt_o, done_o, busy_o, err_o} !== 6'b0) begin
            n_fails++;
            $display("FAIL reset_flags: got %b want 000000",
                     {tile_valid_o, tile_last_o, tile_evt_o, done_o, busy_o, err_o});
        end
        n_asserts++;
        if (tile_addr_o !== 32'h0 || tile_idx_o !== 16'h0) begin
            n_fails++;
            $display("FAIL reset_addr_idx: got %h/%h want 0/0", tile_addr_o, tile_idx_o);
        end
        rst_ni = 1'b1;
        cyc();
        n_asserts++;
        if (busy_o !== 1'b0 || tile_valid_o !== 1'b0) begin
            n_fails++;
            $display("FAIL post_reset_idle: busy=%b valid=%b want 0/0", busy_o, tile_valid_o);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int evts = 0;
        logic [ADDR_WIDTH-1:0] exp_addr;
        tile_ready_i = 1'b1;
        start_job(16'd3, 32'h1000, 32'h40);
        for (int t = 0; t < 3; t++) begin
            wait_valid(ok);
            n_asserts++;
            if (!ok) begin
                n_fails++;
                $display("FAIL basic_valid_timeout: tile %0d never valid", t);
            end
            exp_addr = 32'h1000 + 32'(t) * 32'h40;
            n_asserts++;
            if (tile_addr_o !== exp_addr || tile_idx_o !== 16'(t) || tile_last_o !== (t == 2)) begin
                n_fails++;
                $display("FAIL basic_tile%0d: addr=%h idx=%0d last=%b want %h/%0d/%b",
                         t, tile_addr_o, tile_idx_o, tile_last_o, exp_addr, t, (t == 2));
            end
            cyc();
            n_asserts++;
            if (tile_valid_o !== 1'b0 || busy_o !== 1'b1) begin
                n_fails++;
                $display("FAIL basic_wait%0d: valid=%b busy=%b want 0/1", t, tile_valid_o, busy_o);
            end
            cyc();
            tile_done_i = 1'b1;
            cyc();
            tile_done_i = 1'b0;
            if (tile_evt_o === 1'b1) evts++;
            n_asserts++;
            if (done_o !== (t == 2)) begin
                n_fails++;
                $display("FAIL basic_done_t%0d: done=%b want %b", t, done_o, (t == 2));
            end
        end
        cyc();
        n_asserts++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_fails++;
            $display("FAIL basic_end: done=%b busy=%b err=%b want 0/0/0", done_o, busy_o, err_o);
        end
        n_asserts++;
        if (evts != 3) begin
            n_fails++;
            $display("FAIL basic_evt_count: got %0d want 3", evts);
        end
    endtask

    task automatic test_zero_tiles();
        start_job(16'd0, 32'h4000, 32'h10);
        n_asserts++;
        if (done_o !== 1'b1 || busy_o !== 1'b1 || tile_valid_o !== 1'b0) begin
            n_fails++;
            $display("FAIL zero_t1: done=%b busy=%b valid=%b want 1/1/0", done_o, busy_o, tile_valid_o);
        end
        cyc();
        n_asserts++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || tile_valid_o !== 1'b0) begin
            n_fails++;
            $display("FAIL zero_t2: done=%b busy=%b valid=%b want 0/0/0", done_o, busy_o, tile_valid_o);
        end
    endtask

    task automatic test_backpressure();
        tile_ready_i = 1'b0;
        start_job(16'd1, 32'h2000, 32'h10);
        for (int c = 0; c < 5; c++) begin
            n_asserts++;
            if (tile_valid_o !== 1'b1 || tile_addr_o !== 32'h2000 || tile_idx_o !== 16'd0
                || tile_last_o !== 1'b1) begin
                n_fails++;
                $display("FAIL bp_hold_c%0d: valid=%b addr=%h idx=%0d last=%b want 1/2000/0/1",
                         c, tile_valid_o, tile_addr_o, tile_idx_o, tile_last_o);
            end
            cyc();
        end
        tile_ready_i = 1'b1;
        n_asserts++;
        if (tile_valid_o !== 1'b1) begin
            n_fails++;
            $display("FAIL bp_c6_valid: got %b want 1", tile_valid_o);
        end
        cyc();
        n_asserts++;
        if (tile_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fails++;
            $display("FAIL bp_accept: valid=%b busy=%b want 0/1", tile_valid_o, busy_o);
        end
        tile_done_i = 1'b1;
        cyc();
        tile_done_i = 1'b0;
        n_asserts++;
        if (tile_evt_o !== 1'b1 || done_o !== 1'b1) begin
            n_fails++;
            $display("FAIL bp_done: evt=%b done=%b want 1/1", tile_evt_o, done_o);
        end
        cyc();
    endtask

    task automatic test_addr_wrap();
        bit ok;
        tile_ready_i = 1'b1;
        start_job(16'd2, 32'hFFFF_FFC0, 32'h40);
        n_asserts++;
        if (tile_addr_o !== 32'hFFFF_FFC0 || tile_valid_o !== 1'b1) begin
            n_fails++;
            $display("FAIL wrap_tile0: addr=%h valid=%b want ffffffc0/1", tile_addr_o, tile_valid_o);
        end
        cyc();
        tile_done_i = 1'b1;
        cyc();
        tile_done_i = 1'b0;
        wait_valid(ok);
        n_asserts++;
        if (!ok || tile_addr_o !== 32'h0 || tile_idx_o !== 16'd1 || tile_last_o !== 1'b1) begin
            n_fails++;
            $display("FAIL wrap_tile1: ok=%b addr=%h idx=%0d last=%b want 1/00000000/1/1",
                     ok, tile_addr_o, tile_idx_o, tile_last_o);
        end
        cyc();
        tile_done_i = 1'b1;
        cyc();
        tile_done_i = 1'b0;
        n_asserts++;
        if (done_o !== 1'b1 || err_o !== 1'b0) begin
            n_fails++;
            $display("FAIL wrap_done: done=%b err=%b want 1/0", done_o, err_o);
        end
        cyc();
    endtask

    task automatic test_errors_and_clear();
        bit ok;
        // Spurious completion while idle.
        tile_done_i = 1'b1;
        cyc();
        tile_done_i = 1'b0;
        cyc();
        cyc();
        n_asserts++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fails++;
            $display("FAIL err_sticky: err=%b busy=%b want 1/0", err_o, busy_o);
        end
        // Start while busy must not disturb the running job.
        tile_ready_i = 1'b0;
        start_job(16'd2, 32'h3000, 32'h100);
        cfg_n_tiles_i   = 16'd5;
        cfg_base_addr_i = 32'h9000;
        cfg_stride_i    = 32'h4;
        start_i         = 1'b1;
        cyc();
        start_i         = 1'b0;
        n_asserts++;
        if (tile_addr_o !== 32'h3000 || tile_idx_o !== 16'd0 || tile_last_o !== 1'b0) begin
            n_fails++;
            $display("FAIL busy_start_t0: addr=%h idx=%0d last=%b want 3000/0/0",
                     tile_addr_o, tile_idx_o, tile_last_o);
        end
        tile_ready_i = 1'b1;
        cyc();
        tile_done_i = 1'b1;
        cyc();
        tile_done_i = 1'b0;
        wait_valid(ok);
        n_asserts++;
        if (!ok || tile_addr_o !== 32'h3100 || tile_idx_o !== 16'd1 || tile_last_o !== 1'b1) begin
            n_fails++;
            $display("FAIL busy_start_t1: ok=%b addr=%h idx=%0d last=%b want 1/3100/1/1",
                     ok, tile_addr_o, tile_idx_o, tile_last_o);
        end
        cyc();
        n_asserts++;
        if (err_o !== 1'b1 || tile_valid_o !== 1'b0) begin
            n_fails++;
            $display("FAIL pre_clear: err=%b valid=%b want 1/0", err_o, tile_valid_o);
        end
        // Clear while waiting for the last tile.
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        n_asserts++;
        if (busy_o !== 1'b0 || err_o !== 1'b0 || done_o !== 1'b0 || tile_valid_o !== 1'b0
            || tile_idx_o !== 16'd0) begin
            n_fails++;
            $display("FAIL clear: busy=%b err=%b done=%b valid=%b idx=%0d want 0/0/0/0/0",
                     busy_o, err_o, done_o, tile_valid_o, tile_idx_o);
        end
        cyc();
        n_asserts++;
        if (done_o !== 1'b0 || tile_evt_o !== 1'b0) begin
            n_fails++;
            $display("FAIL clear_after: done=%b evt=%b want 0/0", done_o, tile_evt_o);
        end
        // Completion in the handshake cycle is a protocol error.
        start_job(16'd1, 32'h6000, 32'h10);
        tile_done_i = 1'b1;
        cyc();
        tile_done_i = 1'b0;
        n_asserts++;
        if (err_o !== 1'b1 || tile_valid_o !== 1'b0 || busy_o !== 1'b1 || tile_evt_o !== 1'b0) begin
            n_fails++;
            $display("FAIL done_at_accept: err=%b valid=%b busy=%b evt=%b want 1/0/1/0",
                     err_o, tile_valid_o, busy_o, tile_evt_o);
        end
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
    endtask

    task automatic test_async_reset();
        bit ok;
        tile_ready_i = 1'b0;
        start_job(16'd1, 32'h7000, 32'h10);
        n_asserts++;
        if (tile_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fails++;
            $display("FAIL arst_pre: valid=%b busy=%b want 1/1", tile_valid_o, busy_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_asserts++;
        if ({tile_valid_o, tile_last_o, busy_o, done_o, err_o} !== 5'b0
            || tile_addr_o !== 32'h0 || tile_idx_o !== 16'h0) begin
            n_fails++;
            $display("FAIL arst_immediate: flags=%b addr=%h idx=%h want 00000/0/0",
                     {tile_valid_o, tile_last_o, busy_o, done_o, err_o}, tile_addr_o, tile_idx_o);
        end
        cyc();
        rst_ni = 1'b1;
        cyc();
        tile_ready_i = 1'b1;
        start_job(16'd1, 32'h5000, 32'h10);
        wait_valid(ok);
        n_asserts++;
        if (!ok || tile_addr_o !== 32'h5000 || tile_last_o !== 1'b1) begin
            n_fails++;
            $display("FAIL arst_job: ok=%b addr=%h last=%b want 1/5000/1", ok, tile_addr_o, tile_last_o);
        end
        cyc();
        cyc();
        tile_done_i = 1'b1;
        cyc();
        tile_done_i = 1'b0;
        n_asserts++;
        if (done_o !== 1'b1 || tile_evt_o !== 1'b1 || err_o !== 1'b0) begin
            n_fails++;
            $display("FAIL arst_job_done: done=%b evt=%b err=%b want 1/1/0", done_o, tile_evt_o, err_o);
        end
        cyc();
        n_asserts++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fails++;
            $display("FAIL arst_job_idle: busy=%b done=%b want 0/0", busy_o, done_o);
        end
    endtask

    initial begin
        rst_ni          = 1'b0;
        clear_i         = 1'b0;
        start_i         = 1'b0;
        cfg_n_tiles_i   = '0;
        cfg_base_addr_i = '0;
        cfg_stride_i    = '0;
        tile_ready_i    = 1'b0;
        tile_done_i     = 1'b0;
        cyc();
        cyc();
        test_reset();
        test_basic();
        test_zero_tiles();
        test_backpressure();
        test_addr_wrap();
        test_errors_and_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule : tb_hwpe_ctrl_tile_sequencer

`default_nettype wire

// File: doc/hwpe_ctrl_tile_sequencer.md
Name: hwpe_ctrl_tile_sequencer

Overview:
- Downstream consumer of the control slave's start/is_working outputs.
- On a start pulse it latches a job configuration (tile count, base address, stride) and issues one tile at a time to the engine/streamer via a valid/ready handshake.
- It waits for each tile's completion pulse, then returns a single-cycle done pulse that feeds the control slave's done input.
- Exactly one tile is outstanding at any time.

Parameters:
- CNT_WIDTH, 16, width of tile count and tile index.
- ADDR_WIDTH, 32, width of base, stride and tile address.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous soft clear; highest priority after reset.
- start_i  in  1  job start pulse.
- cfg_n_tiles_i  in  CNT_WIDTH  tile count; 0 is legal.
- cfg_base_addr_i  in  ADDR_WIDTH  address of tile 0.
- cfg_stride_i  in  ADDR_WIDTH  address increment per tile (unsigned).
- tile_valid_o  out  1  tile request valid.
- tile_ready_i  in  1  engine accepts tile.
- tile_addr_o  out  ADDR_WIDTH  current tile address.
- tile_idx_o  out  CNT_WIDTH  current tile index.
- tile_last_o  out  1  current tile is the final one.
- tile_done_i  in  1  engine completion pulse for the accepted tile.
- tile_evt_o  out  1  one-cycle pulse per completed tile.
- done_o  out  1  one-cycle job-done pulse.
- busy_o  out  1  state != IDLE.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset values: all outputs 0, state IDLE, latched cfg 0.
- clear_i: next state IDLE, counters 0, err_o cleared, no done_o or tile_evt_o pulse.
- States: IDLE, ISSUE, WAIT, DONE. State register; all outputs are registered or decoded from registered state.
- IDLE:
  - start_i=1 latches cfg_* (cfg inputs are don't-care afterwards) and sets idx=0, addr=base.
  - Next state is ISSUE if n_tiles>0, else DONE.
  - start_i=0 stays in IDLE.
- ISSUE:
  - tile_valid_o=1; addr, idx and last are held stable until handshake.
  - tile_valid_o never drops without ready (AXI-style).
  - On valid&ready, go to WAIT.
- WAIT:
  - tile_done_i=1 pulses tile_evt_o in the next cycle.
  - If idx==n_tiles-1, go to DONE.
  - Otherwise idx+=1, addr+=stride (modulo 2^ADDR_WIDTH, wrap silent), go to ISSUE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- tile_last_o = (idx == n_tiles-1) while in ISSUE/WAIT; 0 otherwise.
- Latency:
  - start_i at cycle t gives tile_valid_o at t+1 (n>0), or done_o at t+1 (n=0).
  - Last tile_done_i at t gives done_o at t+1 and busy_o=0 at t+2.
  - Minimum per-tile turnaround: 2 cycles.
- start_i while busy_o=1: ignored, no effect on cfg.
- tile_done_i outside WAIT: err_o set (sticky until clear/reset); the pulse is otherwise ignored.
- tile_done_i in the same cycle as the handshake in ISSUE: counts as error (done must follow acceptance).
- n_tiles = 2^CNT_WIDTH-1: index reaches the max value with no overflow; no wrap permitted.
- Reset or clear mid-job aborts immediately; the engine-side abort is the owner's responsibility (the clear is shared).

Decomposition:
- hwpe_ctrl_package:
  - typedef tile_seq_cfg_t {n_tiles, base_addr, stride}.
  - typedef tile_seq_flags_t {tile_valid, tile_idx, tile_last, tile_evt, done, busy, err}.
  - enum tile_seq_state_t.
- Sub-module hwpe_ctrl_tile_addrgen: index counter plus address accumulator with load/step/clear inputs and a last flag. The FSM stays in the top module.

Test Plan:
- n_tiles=3, base=0x1000, stride=0x40, ready always 1, done 2 cycles after accept -> tile_addr 0x1000/0x1040/0x1080, idx 0/1/2, last only on idx 2; three tile_evt_o pulses; done_o exactly once, one cycle after the third tile_done_i.
- n_tiles=0, start pulse -> done_o at t+1, tile_valid_o never asserted, busy_o high for 1 cycle.
- Backpressure: tile_ready_i low for 5 cycles -> tile_valid_o, addr and idx stable throughout; handshake on cycle 6; no tile skipped.
- base=0xFFFF_FFC0, stride=0x40, n=2 -> second tile_addr=0x0000_0000, no error.
- Spurious tile_done_i in IDLE -> err_o=1 and sticky; start_i while busy ignored (cfg unchanged); clear_i mid-WAIT -> IDLE next cycle, err_o=0, no done_o.
- Async reset asserted in ISSUE -> all outputs 0 immediately; after release, a new job with n=1 completes normally.
